mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the block RAM arbiter:
// read-owner tags and arbiter state encodings.
package mem_arbiter_pkg;

  typedef logic [1:0] own_t;
  typedef logic       state_t;

  localparam own_t OWN_NONE = 2'd0;
  localparam own_t OWN_IF   = 2'd1;
  localparam own_t OWN_D    = 2'd2;

  localparam state_t ST_BOOT = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  function automatic logic is_misaligned(
    input logic [1:0] lsb
  );
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port block RAM arbiter: boot loader, fetch and data
// share one port with fixed priority and a fetch starvation guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int MAX_STREAK = 4,
  parameter int BOOT_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W+1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              ld_done,
  output logic              ld_ack,
  input  logic              if_req,
  input  logic [ADDR_W+1:0] if_addr,
  output logic              if_ack,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W+1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              booting
);

  localparam int AW = ADDR_W + 2;
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam state_t ST_RESET = (BOOT_EN != 0) ? ST_BOOT : ST_RUN;

  state_t          state_q;
  state_t          state_d;
  own_t            owner_q;
  own_t            owner_d;
  logic [SW-1:0]   streak_q;
  logic [SW-1:0]   streak_d;
  logic            mis_q;
  logic            mis_d;
  logic            fetch_win;
  logic [AW-1:0]   sel_addr;
  logic            any_ack;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave BOOT only once no loader write is in flight
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: begin
        if (ld_done && !ld_ack) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: state_d = ST_RUN;
      default: state_d = ST_RESET;
    endcase
  end

  // Grant decode
  always_comb begin
    ld_ack    = 1'b0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    fetch_win = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        ld_ack = ld_req;
      end
      ST_RUN: begin
        fetch_win = if_req &&
                    (!d_req || streak_q == STREAK_MAX);
        if_ack    = fetch_win;
        d_ack     = d_req && !fetch_win;
      end
      default: begin
        ld_ack = 1'b0;
      end
    endcase
  end

  // RAM port mux driven by whichever requester was granted
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    sel_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      ld_ack: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        sel_addr  = ld_addr;
        ram_wdata = ld_wdata;
      end
      if_ack: begin
        ram_en   = 1'b1;
        sel_addr = if_addr;
      end
      d_ack: begin
        ram_en    = 1'b1;
        ram_we    = d_we;
        sel_addr  = d_addr;
        ram_wdata = d_wdata;
      end
      default: begin
        ram_en = 1'b0;
      end
    endcase
  end

  assign ram_addr = sel_addr[AW-1:2];
  assign any_ack  = ld_ack | if_ack | d_ack;

  // Starvation counter
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_ack) begin
      streak_d = '0;
    end else if (d_ack && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_ack) begin
      owner_d = OWN_IF;
    end else if (d_ack && !d_we) begin
      owner_d = OWN_D;
    end
  end

  always_comb begin
    mis_d = mis_q;
    if (any_ack && is_misaligned(sel_addr[1:0])) begin
      mis_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
      mis_q    <= mis_d;
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign d_rvalid  = (owner_q == OWN_D);
  assign rdata     = ram_rdata;
  assign misalign  = mis_q;
  assign booting   = (state_q == ST_BOOT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural block RAM;
// a table of per-cycle vectors plus reset and BOOT_EN=0 sequences.
module tb_mem_arbiter;

  localparam int AW = 12;

  logic        clk;
  logic        rst;
  logic        ld_req;
  logic [13:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_done;
  logic        if_req;
  logic [13:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [13:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] zero_rdata;

  logic        ld_ack, if_ack, if_rvalid, d_ack, d_rvalid;
  logic [31:0] rdata, ram_wdata;
  logic        misalign, ram_en, ram_we, booting;
  logic [11:0] ram_addr;

  logic        ld_ack1, if_ack1, if_rvalid1, d_ack1, d_rvalid1;
  logic [31:0] rdata1, ram_wdata1;
  logic        misalign1, ram_en1, ram_we1, booting1;
  logic [11:0] ram_addr1;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mem [0:4095];

  mem_arbiter #(.ADDR_W(AW), .MAX_STREAK(4), .BOOT_EN(1)) u0 (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_ack(ld_ack),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rvalid(d_rvalid),
    .rdata(rdata), .misalign(misalign),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .booting(booting)
  );

  mem_arbiter #(.ADDR_W(AW), .MAX_STREAK(4), .BOOT_EN(0)) u1 (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_ack(ld_ack1),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack1),
    .if_rvalid(if_rvalid1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack1), .d_rvalid(d_rvalid1),
    .rdata(rdata1), .misalign(misalign1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(zero_rdata),
    .booting(booting1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural block_ram: read data one cycle after enable
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        ldr;
    logic        ldn;
    logic        ir;
    logic        dr;
    logic        dw;
    logic [13:0] la;
    logic [13:0] ia;
    logic [13:0] da;
    logic [31:0] wd;
    logic [2:0]  ack;
    logic        en;
    logic        we;
    logic [11:0] addr;
    logic        irv;
    logic        drv;
    logic        boot;
    logic        mis;
    logic [31:0] rd;
  } vec_t;

  vec_t v [0:24];

  function automatic vec_t mk(
    input logic ldr, input logic ldn, input logic ir,
    input logic dr, input logic dw,
    input logic [13:0] la, input logic [13:0] ia,
    input logic [13:0] da, input logic [31:0] wd,
    input logic [2:0] ack, input logic en, input logic we,
    input logic [11:0] addr, input logic irv, input logic drv,
    input logic boot, input logic mis, input logic [31:0] rd
  );
    vec_t r;
    r.ldr = ldr; r.ldn = ldn; r.ir = ir; r.dr = dr; r.dw = dw;
    r.la = la; r.ia = ia; r.da = da; r.wd = wd;
    r.ack = ack; r.en = en; r.we = we; r.addr = addr;
    r.irv = irv; r.drv = drv; r.boot = boot; r.mis = mis;
    r.rd = rd;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ld_req = 0; ld_addr = '0; ld_wdata = '0; ld_done = 0;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".acks"}, {29'd0, ld_ack, if_ack, d_ack}, 32'd0);
    chk({tag, ".if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    chk({tag, ".d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    chk({tag, ".ram_en_we"}, {30'd0, ram_en, ram_we}, 32'd0);
    chk({tag, ".ram_addr"}, {20'd0, ram_addr}, 32'd0);
    chk({tag, ".ram_wdata"}, ram_wdata, 32'd0);
    chk({tag, ".misalign"}, {31'd0, misalign}, 32'd0);
    chk({tag, ".booting"}, {31'd0, booting}, 32'd1);
  endtask

  initial begin
    zero_rdata = '0;
    ram_rdata  = '0;
    idle_inputs();
    rst = 1'b1;

    v[0]  = mk(1,0,1,1,0, 14'h10,14'h10,14'h14, 32'hDEADBEEF,
               3'b100,1,1,12'd4, 0,0,1,0, 32'h0);
    v[1]  = mk(1,1,1,1,0, 14'h14,14'h10,14'h14, 32'h11111111,
               3'b100,1,1,12'd5, 0,0,1,0, 32'h0);
    v[2]  = mk(0,1,1,1,0, 14'h0,14'h10,14'h14, 32'h0,
               3'b000,0,0,12'd0, 0,0,1,0, 32'h0);
    v[3]  = mk(1,1,1,0,0, 14'h10,14'h10,14'h0, 32'h0,
               3'b010,1,0,12'd4, 0,0,0,0, 32'h0);
    v[4]  = mk(0,1,0,0,0, 14'h0,14'h0,14'h0, 32'h0,
               3'b000,0,0,12'd0, 1,0,0,0, 32'hDEADBEEF);
    for (int i = 5; i <= 14; i++) begin
      v[i] = mk(0,1,1,1,0, 14'h0,14'h10,14'h14, 32'h0,
                3'b001,1,0,12'd5, 0,1,0,0, 32'h11111111);
    end
    v[5].drv  = 0;
    v[9].ack  = 3'b010; v[9].addr  = 12'd4;
    v[10].irv = 1; v[10].drv = 0; v[10].rd = 32'hDEADBEEF;
    v[14].ack = 3'b010; v[14].addr = 12'd4;
    v[15] = mk(0,1,0,0,0, 14'h0,14'h0,14'h0, 32'h0,
               3'b000,0,0,12'd0, 1,0,0,0, 32'hDEADBEEF);
    v[16] = mk(0,1,0,1,1, 14'h0,14'h0,14'h22, 32'hCAFEF00D,
               3'b001,1,1,12'd8, 0,0,0,0, 32'h0);
    v[17] = mk(0,1,0,1,0, 14'h0,14'h0,14'h20, 32'h0,
               3'b001,1,0,12'd8, 0,0,0,1, 32'h0);
    v[18] = mk(0,1,0,0,0, 14'h0,14'h0,14'h0, 32'h0,
               3'b000,0,0,12'd0, 0,1,0,1, 32'hCAFEF00D);
    for (int i = 19; i <= 23; i++) begin
      v[i] = mk(0,1,1,1,0, 14'h0,14'h10,14'h20, 32'h0,
                3'b001,1,0,12'd8, 0,1,0,1, 32'hCAFEF00D);
    end
    v[19].drv = 0;
    v[22].ir  = 0;
    v[24] = mk(0,1,0,0,0, 14'h0,14'h0,14'h0, 32'h0,
               3'b000,0,0,12'd0, 0,1,0,1, 32'hCAFEF00D);

    #2;
    check_reset_state("reset");
    chk("u1.booting_reset", {31'd0, booting1}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    // Fetch while u0 boots: u0 must refuse, u1 (BOOT_EN=0) must serve
    @(negedge clk);
    if_req = 1; if_addr = 14'h10;
    #2;
    chk("boot.if_ack", {31'd0, if_ack}, 32'd0);
    chk("u1.if_ack", {31'd0, if_ack1}, 32'd1);
    chk("u1.booting", {31'd0, booting1}, 32'd0);

    for (int i = 0; i <= 24; i++) begin
      @(negedge clk);
      ld_req = v[i].ldr; ld_done = v[i].ldn;
      ld_addr = v[i].la; ld_wdata = v[i].wd;
      if_req = v[i].ir; if_addr = v[i].ia;
      d_req = v[i].dr; d_we = v[i].dw;
      d_addr = v[i].da; d_wdata = v[i].wd;
      #2;
      chk($sformatf("v%0d.acks", i),
          {29'd0, ld_ack, if_ack, d_ack}, {29'd0, v[i].ack});
      chk($sformatf("v%0d.ram_en", i),
          {31'd0, ram_en}, {31'd0, v[i].en});
      chk($sformatf("v%0d.ram_we", i),
          {31'd0, ram_we}, {31'd0, v[i].we});
      chk($sformatf("v%0d.ram_addr", i),
          {20'd0, ram_addr}, {20'd0, v[i].addr});
      if (v[i].we || !v[i].en)
        chk($sformatf("v%0d.ram_wdata", i), ram_wdata,
            v[i].we ? v[i].wd : 32'h0);
      chk($sformatf("v%0d.if_rvalid", i),
          {31'd0, if_rvalid}, {31'd0, v[i].irv});
      chk($sformatf("v%0d.d_rvalid", i),
          {31'd0, d_rvalid}, {31'd0, v[i].drv});
      chk($sformatf("v%0d.booting", i),
          {31'd0, booting}, {31'd0, v[i].boot});
      chk($sformatf("v%0d.misalign", i),
          {31'd0, misalign}, {31'd0, v[i].mis});
      if (v[i].irv || v[i].drv)
        chk($sformatf("v%0d.rdata", i), rdata, v[i].rd);
    end

    // Reset arriving the cycle after a load grant kills its rvalid
    @(negedge clk);
    idle_inputs();
    d_req = 1; d_addr = 14'h14;
    #2;
    chk("rstrd.d_ack", {31'd0, d_ack}, 32'd1);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #2;
    check_reset_state("rstrd");
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rstrd.d_rvalid_after", {31'd0, d_rvalid}, 32'd0);
    chk("rstrd.booting_after", {31'd0, booting}, 32'd1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
